axi_multicut_chan: RTL and testbench
====================================

Name: axi_multicut_chan

Overview:
- Configurable AXI4 pipeline: independent cut depth on each of the five channels (AW, W, B, AR, R), plus a selectable slice mode.
- Each cut is a valid/ready register slice; order and content are preserved.
- Sits on long AXI4 buses between crossbar ports and distant masters/slaves, replacing uniform-depth cut chains where channels have different timing slack.
- Provides an idle status for clock-gating/power control.

Parameters:
- ADDR_WIDTH, -1: AXI address width (must be set >0)
- DATA_WIDTH, -1: AXI data width (must be set >0)
- ID_WIDTH, -1: AXI ID width (must be set >0)
- USER_WIDTH, -1: AXI user width (must be set >0)
- AW_CUTS, 1: slices on AW channel, >=0
- W_CUTS, 1: slices on W channel, >=0
- B_CUTS, 1: slices on B channel, >=0
- AR_CUTS, 1: slices on AR channel, >=0
- R_CUTS, 1: slices on R channel, >=0
- HALF_MODE, 0: 0 = full spill slices (2 entries, 1 beat/cycle); 1 = half slices (1 entry, 1 beat/2 cycles, half the area)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active low
- in  AXI_BUS.Slave  interface  upstream side; connects to the master
- out  AXI_BUS.Master  interface  downstream side; connects to the slave
- idle_o  output  1  high when every slice on every channel is empty

Behaviour:
- Slice payload: all signals of the channel except valid/ready.
  - AW/AR: id, addr, len, size, burst, lock, cache, prot, qos, region, atop (AW only), user.
  - W: data, strb, last, user.
  - B: id, resp, user.
  - R: id, data, resp, last, user.
- Direction: forward channels (AW, W, AR) flow in->out; B and R flow out->in.
- Channel with 0 cuts: combinational wire for payload, valid and ready; contributes nothing to idle_o.
- Full slice (HALF_MODE=0): slots A (head) and B (spill).
  - valid_out = A_full.
  - ready_in = !B_full, so ready_in is registered and has no combinational path from ready_out.
  - Accepted beat goes to A if A is empty or A is being popped this cycle; otherwise it goes to B.
  - On pop with B_full: B moves to A.
  - Simultaneous push and pop with A full, B empty: A takes the new beat, B stays empty.
- Half slice (HALF_MODE=1): one slot.
  - ready_in = !full, valid_out = full.
  - Push and pop in the same cycle are impossible.
- Latency: N cuts give N cycles from input handshake to output valid; there is no combinational valid or payload path when N>0.
- Throughput:
  - Full mode: 1 beat/cycle sustained under continuous ready.
  - Half mode: 1 beat per 2 cycles.
- Chaining: N slices in series; stage k out feeds stage k+1 in. Stage 0 is at the source side for that direction.
- Payload is held stable while valid_out=1 and ready_out=0 (AXI rule). Valid is never withdrawn before the handshake.
- idle_o: combinational AND of !A_full && !B_full over all slices. It is 1 when all cut counts are 0. It may be 1 while a combinational (0-cut) channel is handshaking.
- Reset (asynchronous, any time, including mid-burst):
  - All slots are emptied and in-flight beats are discarded.
  - Every slice output valid is 0, so out.aw/w/ar_valid=0 and in.b/r_valid=0 on a cut channel.
  - ready_in=1 on every slice. idle_o=1.
  - Payload registers reset to 0.
- No reordering between IDs or channels. AW/W relative skew is allowed by AXI and is not compensated.
- Elaboration checks (non-synthesis): all *_CUTS >= 0; widths > 0.

Test Plan:
- Reset then AW_CUTS=W_CUTS=B_CUTS=AR_CUTS=R_CUTS=2, HALF_MODE=0, idle bus -> all out valids 0, in.aw_ready=1, idle_o=1.
- Push 16 back-to-back AR beats, addr 0x1000+4k, downstream ar_ready=1 -> out.ar_valid rises exactly 2 cycles after the first handshake; 16 beats leave on 16 consecutive cycles in order; idle_o returns to 1 two cycles after the last.
- R burst len=7, in.r_ready toggling 1,0,0,1 pseudo-randomly -> all 8 beats with data/last intact and in order; no beat lost or duplicated; payload stable while stalled; out.r_ready never depends combinationally on in.r_ready.
- HALF_MODE=1, W_CUTS=3, 8 beats, out.w_ready=1 -> first out.w_valid 3 cycles after the first accept; one beat per 2 cycles thereafter; total 3+2*7 cycles to the last beat.
- AW_CUTS=0, B_CUTS=4 -> AW payload/valid visible on out the same cycle; B response id=5 resp=SLVERR reaches in.b 4 cycles after the out.b handshake.
- Assert rst_ni with 2 W beats held in slices and a stalled downstream -> out.w_valid=0 and idle_o=1 immediately (asynchronously); after release the bus accepts new transactions normally.

Source files
------------

// File: rtl/axi_multicut_chan_if.sv
// ============================================================================
//  Module   : AXI_BUS (interface)
//  Purpose  : AXI4 bus bundle (AW, W, B, AR, R) with Master/Slave modports.
//  Ports    : none; the bundle is instantiated and handed to modules through
//             its Master (drives requests) or Slave (drives responses)
//             modport.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface AXI_BUS #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  // Write address
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [5:0]              aw_atop;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;
  // Write data
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;
  // Write response
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;
  // Read address
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;
  // Read data
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

`default_nettype wire

// File: rtl/axi_multicut_chan.sv
// ============================================================================
//  Module   : axi_multicut_chan (+ axi_multicut_chan_slice,
//                                  axi_multicut_chan_pipe)
//  Purpose  : AXI4 pipeline with an independent number of valid/ready
//             register slices on each of the five channels, in full (spill,
//             1 beat/cycle) or half (single slot, 1 beat/2 cycles) mode.
//  Ports    : clk_i   - clock
//             rst_ni  - asynchronous reset, active low
//             in      - upstream side (AXI_BUS.Slave, faces the master)
//             out     - downstream side (AXI_BUS.Master, faces the slave)
//             idle_o  - high when every slice of every channel is empty
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// One valid/ready register slice.
// ----------------------------------------------------------------------------
module axi_multicut_chan_slice #(
  parameter int WIDTH     = 1,
  parameter bit HALF_MODE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_idle
);
  if (HALF_MODE) begin : g_half
    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // ready depends only on the slot state, so a slot can never be
    // filled and drained in the same cycle.
    assign o_ready = !r_full;
    assign o_valid = r_full;
    assign o_data  = r_data;
    assign o_idle  = !r_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_full <= 1'b0;
        r_data <= '0;
      end else if (r_full) begin
        if (i_ready) r_full <= 1'b0;
      end else if (i_valid) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end
    end
  end else begin : g_full
    // Slot A is the head that drives the output; slot B catches the beat
    // that arrives while A is stalled, which lets ready be a pure register.
    logic             r_a_full;
    logic             r_b_full;
    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic             w_push;
    logic             w_pop;

    assign o_ready = !r_b_full;
    assign o_valid = r_a_full;
    assign o_data  = r_a_data;
    assign o_idle  = !r_a_full && !r_b_full;
    assign w_push  = i_valid && !r_b_full;
    assign w_pop   = r_a_full && i_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_a_full <= 1'b0;
        r_b_full <= 1'b0;
        r_a_data <= '0;
        r_b_data <= '0;
      end else if (w_pop) begin
        if (r_b_full) begin
          // Spill drains into the head; no push is possible this cycle.
          r_a_data <= r_b_data;
          r_b_full <= 1'b0;
        end else if (w_push) begin
          r_a_data <= i_data;
        end else begin
          r_a_full <= 1'b0;
        end
      end else if (w_push) begin
        if (!r_a_full) begin
          r_a_data <= i_data;
          r_a_full <= 1'b1;
        end else begin
          r_b_data <= i_data;
          r_b_full <= 1'b1;
        end
      end
    end
  end
endmodule

// ----------------------------------------------------------------------------
// CUTS slices in series; stage 0 sits on the source side. Zero cuts is a
// plain wire that never reports busy.
// ----------------------------------------------------------------------------
module axi_multicut_chan_pipe #(
  parameter int WIDTH     = 1,
  parameter int CUTS      = 1,
  parameter bit HALF_MODE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_idle
);
  if (CUTS <= 0) begin : g_wire
    logic w_unused;
    assign w_unused = clk_i ^ rst_ni;
    assign o_valid  = i_valid;
    assign o_ready  = i_ready;
    assign o_data   = i_data;
    assign o_idle   = 1'b1;
  end else begin : g_cut
    logic [CUTS:0]    w_valid;
    logic [CUTS:0]    w_ready;
    logic [WIDTH-1:0] w_data [CUTS+1];
    logic [CUTS-1:0]  w_idle;

    assign w_valid[0]    = i_valid;
    assign o_ready       = w_ready[0];
    assign w_data[0]     = i_data;
    assign o_valid       = w_valid[CUTS];
    assign w_ready[CUTS] = i_ready;
    assign o_data        = w_data[CUTS];
    assign o_idle        = &w_idle;

    for (genvar k = 0; k < CUTS; k++) begin : g_stage
      axi_multicut_chan_slice #(
        .WIDTH     (WIDTH),
        .HALF_MODE (HALF_MODE)
      ) u_slice (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (w_valid[k]),
        .o_ready (w_ready[k]),
        .i_data  (w_data[k]),
        .o_valid (w_valid[k+1]),
        .i_ready (w_ready[k+1]),
        .o_data  (w_data[k+1]),
        .o_idle  (w_idle[k])
      );
    end
  end
endmodule

// ----------------------------------------------------------------------------
// Top: packs each channel into a flat payload and runs it through its pipe.
// ----------------------------------------------------------------------------
module axi_multicut_chan #(
  parameter int ADDR_WIDTH = -1,
  parameter int DATA_WIDTH = -1,
  parameter int ID_WIDTH   = -1,
  parameter int USER_WIDTH = -1,
  parameter int AW_CUTS    = 1,
  parameter int W_CUTS     = 1,
  parameter int B_CUTS     = 1,
  parameter int AR_CUTS    = 1,
  parameter int R_CUTS     = 1,
  parameter int HALF_MODE  = 0
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  AXI_BUS.Slave  in,
  AXI_BUS.Master out,
  output logic   idle_o
);
  localparam int c_aw_width = ID_WIDTH + ADDR_WIDTH + USER_WIDTH + 35;
  localparam int c_ar_width = ID_WIDTH + ADDR_WIDTH + USER_WIDTH + 29;
  localparam int c_w_width  = DATA_WIDTH + DATA_WIDTH/8 + 1 + USER_WIDTH;
  localparam int c_b_width  = ID_WIDTH + 2 + USER_WIDTH;
  localparam int c_r_width  = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;
  localparam bit c_half     = (HALF_MODE != 0);

  if (AW_CUTS < 0 || W_CUTS < 0 || B_CUTS < 0 || AR_CUTS < 0 || R_CUTS < 0)
  begin : g_err_cuts
    $error("axi_multicut_chan: cut counts must be >= 0");
  end
  if (ADDR_WIDTH <= 0 || DATA_WIDTH <= 0 || ID_WIDTH <= 0 || USER_WIDTH <= 0)
  begin : g_err_width
    $error("axi_multicut_chan: bus widths must be > 0");
  end

  logic [c_aw_width-1:0] w_aw_in, w_aw_out;
  logic [c_w_width-1:0]  w_w_in,  w_w_out;
  logic [c_b_width-1:0]  w_b_in,  w_b_out;
  logic [c_ar_width-1:0] w_ar_in, w_ar_out;
  logic [c_r_width-1:0]  w_r_in,  w_r_out;
  logic                  w_idle_aw, w_idle_w, w_idle_b, w_idle_ar, w_idle_r;

  // Forward channels: in -> out
  assign w_aw_in = {in.aw_id, in.aw_addr, in.aw_len, in.aw_size, in.aw_burst,
                    in.aw_lock, in.aw_cache, in.aw_prot, in.aw_qos,
                    in.aw_region, in.aw_atop, in.aw_user};
  assign {out.aw_id, out.aw_addr, out.aw_len, out.aw_size, out.aw_burst,
          out.aw_lock, out.aw_cache, out.aw_prot, out.aw_qos, out.aw_region,
          out.aw_atop, out.aw_user} = w_aw_out;

  assign w_w_in = {in.w_data, in.w_strb, in.w_last, in.w_user};
  assign {out.w_data, out.w_strb, out.w_last, out.w_user} = w_w_out;

  assign w_ar_in = {in.ar_id, in.ar_addr, in.ar_len, in.ar_size, in.ar_burst,
                    in.ar_lock, in.ar_cache, in.ar_prot, in.ar_qos,
                    in.ar_region, in.ar_user};
  assign {out.ar_id, out.ar_addr, out.ar_len, out.ar_size, out.ar_burst,
          out.ar_lock, out.ar_cache, out.ar_prot, out.ar_qos, out.ar_region,
          out.ar_user} = w_ar_out;

  // Response channels: out -> in
  assign w_b_in = {out.b_id, out.b_resp, out.b_user};
  assign {in.b_id, in.b_resp, in.b_user} = w_b_out;

  assign w_r_in = {out.r_id, out.r_data, out.r_resp, out.r_last, out.r_user};
  assign {in.r_id, in.r_data, in.r_resp, in.r_last, in.r_user} = w_r_out;

  axi_multicut_chan_pipe #(.WIDTH(c_aw_width), .CUTS(AW_CUTS), .HALF_MODE(c_half))
  u_aw (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .i_valid (in.aw_valid),  .o_ready (in.aw_ready),  .i_data (w_aw_in),
    .o_valid (out.aw_valid), .i_ready (out.aw_ready), .o_data (w_aw_out),
    .o_idle  (w_idle_aw)
  );

  axi_multicut_chan_pipe #(.WIDTH(c_w_width), .CUTS(W_CUTS), .HALF_MODE(c_half))
  u_w (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .i_valid (in.w_valid),  .o_ready (in.w_ready),  .i_data (w_w_in),
    .o_valid (out.w_valid), .i_ready (out.w_ready), .o_data (w_w_out),
    .o_idle  (w_idle_w)
  );

  axi_multicut_chan_pipe #(.WIDTH(c_b_width), .CUTS(B_CUTS), .HALF_MODE(c_half))
  u_b (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .i_valid (out.b_valid), .o_ready (out.b_ready), .i_data (w_b_in),
    .o_valid (in.b_valid),  .i_ready (in.b_ready),  .o_data (w_b_out),
    .o_idle  (w_idle_b)
  );

  axi_multicut_chan_pipe #(.WIDTH(c_ar_width), .CUTS(AR_CUTS), .HALF_MODE(c_half))
  u_ar (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .i_valid (in.ar_valid),  .o_ready (in.ar_ready),  .i_data (w_ar_in),
    .o_valid (out.ar_valid), .i_ready (out.ar_ready), .o_data (w_ar_out),
    .o_idle  (w_idle_ar)
  );

  axi_multicut_chan_pipe #(.WIDTH(c_r_width), .CUTS(R_CUTS), .HALF_MODE(c_half))
  u_r (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .i_valid (out.r_valid), .o_ready (out.r_ready), .i_data (w_r_in),
    .o_valid (in.r_valid),  .i_ready (in.r_ready),  .o_data (w_r_out),
    .o_idle  (w_idle_r)
  );

  assign idle_o = w_idle_aw & w_idle_w & w_idle_b & w_idle_ar & w_idle_r;
endmodule

`default_nettype wire

// File: tb/tb_axi_multicut_chan.sv
// ============================================================================
//  Module   : tb_axi_multicut_chan
//  Purpose  : Self-checking bench for axi_multicut_chan. dut_a: two full
//             slices per channel. dut_b: half mode, AW wire, W 3, B 4 cuts.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_multicut_chan;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int UW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle_a, idle_b;
  always #5 clk = ~clk;

  AXI_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) a_in ();
  AXI_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) a_out ();
  AXI_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) b_in ();
  AXI_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) b_out ();

  axi_multicut_chan #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
    .AW_CUTS(2), .W_CUTS(2), .B_CUTS(2), .AR_CUTS(2), .R_CUTS(2), .HALF_MODE(0)
  ) dut_a (.clk_i(clk), .rst_ni(rst_n), .in(a_in), .out(a_out), .idle_o(idle_a));

  axi_multicut_chan #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
    .AW_CUTS(0), .W_CUTS(3), .B_CUTS(4), .AR_CUTS(1), .R_CUTS(1), .HALF_MODE(1)
  ) dut_b (.clk_i(clk), .rst_ni(rst_n), .in(b_in), .out(b_out), .idle_o(idle_b));

  typedef struct {
    logic [63:0] payload;
    int          due;
  } item_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [63:0]   exp_payload;
    int            exp_lat;
  } ar_vec_t;

  int      checks = 0;
  int      failures = 0;
  item_t   sb[$];
  item_t   it;
  ar_vec_t ar_tab[16];
  logic    idle_log[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Step to the next cycle window: inputs are driven 1 time unit after the
  // rising edge and outputs sampled 1 unit later.
  task automatic next_win();
    @(posedge clk);
    #1;
  endtask

  task automatic init_buses();
    {a_in.aw_id, a_in.aw_addr, a_in.aw_len, a_in.aw_size, a_in.aw_burst, a_in.aw_lock,
     a_in.aw_cache, a_in.aw_prot, a_in.aw_qos, a_in.aw_region, a_in.aw_atop,
     a_in.aw_user, a_in.aw_valid} = '0;
    {a_in.w_data, a_in.w_strb, a_in.w_last, a_in.w_user, a_in.w_valid} = '0;
    {a_in.ar_id, a_in.ar_addr, a_in.ar_len, a_in.ar_size, a_in.ar_burst, a_in.ar_lock,
     a_in.ar_cache, a_in.ar_prot, a_in.ar_qos, a_in.ar_region, a_in.ar_user,
     a_in.ar_valid} = '0;
    {a_in.b_ready, a_in.r_ready} = '0;
    {b_in.aw_id, b_in.aw_addr, b_in.aw_len, b_in.aw_size, b_in.aw_burst, b_in.aw_lock,
     b_in.aw_cache, b_in.aw_prot, b_in.aw_qos, b_in.aw_region, b_in.aw_atop,
     b_in.aw_user, b_in.aw_valid} = '0;
    {b_in.w_data, b_in.w_strb, b_in.w_last, b_in.w_user, b_in.w_valid} = '0;
    {b_in.ar_id, b_in.ar_addr, b_in.ar_len, b_in.ar_size, b_in.ar_burst, b_in.ar_lock,
     b_in.ar_cache, b_in.ar_prot, b_in.ar_qos, b_in.ar_region, b_in.ar_user,
     b_in.ar_valid} = '0;
    {b_in.b_ready, b_in.r_ready} = '0;
    {a_out.aw_ready, a_out.w_ready, a_out.ar_ready} = '0;
    {a_out.b_id, a_out.b_resp, a_out.b_user, a_out.b_valid} = '0;
    {a_out.r_id, a_out.r_data, a_out.r_resp, a_out.r_last, a_out.r_user, a_out.r_valid} = '0;
    {b_out.aw_ready, b_out.w_ready, b_out.ar_ready} = '0;
    {b_out.b_id, b_out.b_resp, b_out.b_user, b_out.b_valid} = '0;
    {b_out.r_id, b_out.r_data, b_out.r_resp, b_out.r_last, b_out.r_user, b_out.r_valid} = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, got, first_in, last_in, first_out, last_out, stab_bad, comb_bad;
    logic        prev_stall, rr0;
    logic [38:0] prev_pay, cur_pay;
    logic [15:0] rdy_pat;

    init_buses();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---------------- reset state, idle bus ----------------
    next_win(); #1;
    check("rst_aw_valid", a_out.aw_valid, 0);
    check("rst_w_valid",  a_out.w_valid,  0);
    check("rst_ar_valid", a_out.ar_valid, 0);
    check("rst_b_valid",  a_in.b_valid,   0);
    check("rst_r_valid",  a_in.r_valid,   0);
    check("rst_aw_ready", a_in.aw_ready,  1);
    check("rst_idle",     idle_a,         1);

    // ---------------- 16 back-to-back AR beats (table + scoreboard) --------
    for (int k = 0; k < 16; k++) begin
      ar_tab[k].id          = 4'(k);
      ar_tab[k].addr        = 32'h0000_1000 + 32'(4 * k);
      ar_tab[k].len         = 8'(k);
      ar_tab[k].exp_payload = {20'h0, 4'(k), 32'h0000_1000 + 32'(4 * k), 8'(k)};
      ar_tab[k].exp_lat     = 2;
    end
    sb.delete();
    sent = 0; got = 0; first_in = -1; last_in = -1;
    a_out.ar_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      next_win();
      if (sent < 16) begin
        a_in.ar_valid = 1'b1;
        a_in.ar_id    = ar_tab[sent].id;
        a_in.ar_addr  = ar_tab[sent].addr;
        a_in.ar_len   = ar_tab[sent].len;
      end else begin
        a_in.ar_valid = 1'b0;
      end
      #1;
      idle_log[cyc] = idle_a;
      if (a_in.ar_valid && a_in.ar_ready) begin
        sb.push_back('{payload: ar_tab[sent].exp_payload, due: cyc + ar_tab[sent].exp_lat});
        if (first_in < 0) first_in = cyc;
        last_in = cyc;
        sent++;
      end
      if (a_out.ar_valid && a_out.ar_ready) begin
        check("ar_sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          it = sb.pop_front();
          check("ar_payload", {20'h0, a_out.ar_id, a_out.ar_addr, a_out.ar_len}, it.payload);
          check("ar_latency", 64'(cyc), 64'(it.due));
        end
        got++;
      end
    end
    check("ar_beats_out", 64'(got), 16);
    check("ar_in_back_to_back", 64'(last_in - first_in), 15);
    if (last_in >= 0 && last_in + 3 < 64) begin
      check("ar_idle_busy", idle_log[last_in + 2], 0);
      check("ar_idle_back", idle_log[last_in + 3], 1);
    end
    a_out.ar_ready = 1'b0;

    // ---------------- R burst len=7 with in.r_ready backpressure ----------
    rdy_pat = 16'b1001_1010_0110_1101;
    sb.delete();
    sent = 0; got = 0; stab_bad = 0; comb_bad = 0;
    prev_stall = 1'b0; prev_pay = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      next_win();
      if (sent < 8) begin
        a_out.r_valid = 1'b1;
        a_out.r_id    = 4'h3;
        a_out.r_data  = 32'hA000_0000 + 32'(sent * 32'h111);
        a_out.r_resp  = 2'(sent);
        a_out.r_last  = (sent == 7);
      end else begin
        a_out.r_valid = 1'b0;
      end
      a_in.r_ready = rdy_pat[cyc % 16];
      #1;
      rr0 = a_out.r_ready;
      a_in.r_ready = ~a_in.r_ready;
      #1;
      if (a_out.r_ready !== rr0) comb_bad++;
      a_in.r_ready = ~a_in.r_ready;
      #1;
      cur_pay = {a_in.r_id, a_in.r_data, a_in.r_resp, a_in.r_last};
      if (prev_stall && (!a_in.r_valid || cur_pay != prev_pay)) stab_bad++;
      prev_stall = a_in.r_valid && !a_in.r_ready;
      prev_pay   = cur_pay;
      if (a_out.r_valid && a_out.r_ready) begin
        sb.push_back('{payload: {25'h0, 4'h3, 32'hA000_0000 + 32'(sent * 32'h111),
                                 2'(sent), (sent == 7)}, due: 0});
        sent++;
      end
      if (a_in.r_valid && a_in.r_ready) begin
        check("r_sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          it = sb.pop_front();
          check("r_beat", {25'h0, cur_pay}, it.payload);
        end
        got++;
      end
    end
    a_in.r_ready = 1'b0;
    check("r_beats_out", 64'(got), 8);
    check("r_sb_drained", 64'(sb.size()), 0);
    check("r_stable_while_stalled", 64'(stab_bad), 0);
    check("r_ready_no_comb_path", 64'(comb_bad), 0);

    // ---------------- half mode, W 3 cuts, 8 beats --------------------------
    sb.delete();
    sent = 0; got = 0; first_in = -1; first_out = -1; last_out = -1;
    b_out.w_ready = 1'b1;
    b_in.w_strb   = 4'hF;
    for (int cyc = 0; cyc < 40; cyc++) begin
      next_win();
      b_in.w_valid = (sent < 8);
      b_in.w_data  = 32'h0000_5500 + 32'(sent);
      b_in.w_last  = (sent == 7);
      #1;
      if (b_in.w_valid && b_in.w_ready) begin
        sb.push_back('{payload: {31'h0, 32'h0000_5500 + 32'(sent), (sent == 7)}, due: cyc + 3});
        if (first_in < 0) first_in = cyc;
        sent++;
      end
      if (b_out.w_valid && b_out.w_ready) begin
        check("w_sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          it = sb.pop_front();
          check("w_half_beat", {31'h0, b_out.w_data, b_out.w_last}, it.payload);
          check("w_half_latency", 64'(cyc), 64'(it.due));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
    end
    check("w_half_beats", 64'(got), 8);
    check("w_half_first", 64'(first_out - first_in), 3);
    check("w_half_last",  64'(last_out - first_in), 17);
    b_out.w_ready = 1'b0;

    // ---------------- AW 0 cuts (combinational), B 4 cuts ------------------
    next_win();
    b_in.aw_valid = 1'b1;
    b_in.aw_id    = 4'h6;
    b_in.aw_addr  = 32'hDEAD_0040;
    b_in.aw_len   = 8'h03;
    b_out.aw_ready = 1'b0;
    #1;
    check("aw0_valid",      b_out.aw_valid, 1);
    check("aw0_addr",       b_out.aw_addr, 32'hDEAD_0040);
    check("aw0_id",         b_out.aw_id, 4'h6);
    check("aw0_ready_low",  b_in.aw_ready, 0);
    b_out.aw_ready = 1'b1;
    #1;
    check("aw0_ready_high", b_in.aw_ready, 1);
    next_win();
    b_in.aw_valid = 1'b0;
    #1;
    check("aw0_valid_drop", b_out.aw_valid, 0);

    b_in.b_ready = 1'b1;
    next_win();
    b_out.b_valid = 1'b1;
    b_out.b_id    = 4'h5;
    b_out.b_resp  = 2'b10;
    #1;
    check("b4_accept", b_out.b_ready, 1);
    first_out = -1;
    for (int cyc = 1; cyc < 12; cyc++) begin
      next_win();
      b_out.b_valid = 1'b0;
      #1;
      if (b_in.b_valid && first_out < 0) begin
        first_out = cyc;
        check("b4_id",   b_in.b_id, 4'h5);
        check("b4_resp", b_in.b_resp, 2'b10);
      end
    end
    check("b4_latency", 64'(first_out), 4);

    // ---------------- async reset with W beats held --------------------------
    a_out.w_ready = 1'b0;
    next_win();
    a_in.w_valid = 1'b1; a_in.w_data = 32'h11; a_in.w_last = 1'b0; a_in.w_strb = 4'hF;
    #1;
    check("rst_w_acc0", a_in.w_ready, 1);
    next_win();
    a_in.w_data = 32'h22; a_in.w_last = 1'b1;
    #1;
    check("rst_w_acc1", a_in.w_ready, 1);
    next_win();
    a_in.w_valid = 1'b0;
    next_win(); next_win(); #1;
    check("pre_rst_w_valid", a_out.w_valid, 1);
    check("pre_rst_w_data",  a_out.w_data, 32'h11);
    check("pre_rst_idle",    idle_a, 0);
    rst_n = 1'b0;
    #1;
    check("arst_w_valid", a_out.w_valid, 0);
    check("arst_w_data",  a_out.w_data, 0);
    check("arst_idle",    idle_a, 1);
    check("arst_w_ready", a_in.w_ready, 1);
    next_win();
    rst_n = 1'b1;
    a_out.w_ready = 1'b1;
    next_win();
    a_in.w_valid = 1'b1; a_in.w_data = 32'h33; a_in.w_last = 1'b1;
    #1;
    check("post_rst_accept", a_in.w_ready, 1);
    first_out = -1;
    for (int cyc = 1; cyc < 8; cyc++) begin
      next_win();
      a_in.w_valid = 1'b0;
      #1;
      if (a_out.w_valid && first_out < 0) begin
        first_out = cyc;
        check("post_rst_data", a_out.w_data, 32'h33);
      end
    end
    check("post_rst_latency", 64'(first_out), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
